// File: rtl/mnco_sdr.sv
// Numerically controlled oscillator: 32-bit phase accumulator feeding a 14-iteration
// pipelined CORDIC that produces 10-bit signed sine/cosine with a fixed 16-cycle latency.
module mnco_sdr (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clken,
    input  logic        [31:0] phi_inc_i,
    output logic signed [9:0]  fsin_o,
    output logic signed [9:0]  fcos_o,
    output logic               out_valid
);

    localparam int ITER = 14;
    // 511 / CORDIC gain, with 8 fractional bits
    localparam logic signed [19:0] X_INIT = 20'sd79439;

    logic        [31:0] acc;
    logic        [15:0] vld_p;
    logic signed [19:0] x_p    [0:ITER];
    logic signed [19:0] y_p    [0:ITER];
    logic signed [19:0] z_p    [0:ITER-1];
    logic        [1:0]  quad_p [0:ITER];
    logic               byp_p  [0:ITER];
    logic signed [9:0]  sin_f, cos_f, sin_u, cos_u;

    // atan(2^-i) in angle units where 90 degrees = 2^16
    function automatic logic signed [19:0] atan_lut(input int i);
        case (i)
            0:       return 20'sd32768;
            1:       return 20'sd19344;
            2:       return 20'sd10221;
            3:       return 20'sd5188;
            4:       return 20'sd2604;
            5:       return 20'sd1303;
            6:       return 20'sd652;
            7:       return 20'sd326;
            8:       return 20'sd163;
            9:       return 20'sd81;
            10:      return 20'sd41;
            11:      return 20'sd20;
            12:      return 20'sd10;
            13:      return 20'sd5;
            default: return 20'sd0;
        endcase
    endfunction

    function automatic logic signed [9:0] rnd_sat(input logic signed [19:0] v);
        logic signed [20:0] t;
        t = 21'(v) + 21'sd128;
        t = t >>> 8;
        if (t > 21'sd511)
            return 10'sd511;
        else if (t < -21'sd511)
            return -10'sd511;
        return t[9:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc   <= '0;
            vld_p <= '0;
        end else if (clken) begin
            acc   <= acc + phi_inc_i;
            vld_p <= {vld_p[14:0], 1'b1};
        end
    end

    // Stage p0 folds the phase into the first quadrant; stages p1..p14 are CORDIC rotations
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i <= ITER; i++) begin
                x_p[i]    <= '0;
                y_p[i]    <= '0;
                quad_p[i] <= '0;
                byp_p[i]  <= 1'b0;
            end
            for (int i = 0; i < ITER; i++)
                z_p[i] <= '0;
        end else if (clken) begin
            x_p[0]    <= X_INIT;
            y_p[0]    <= '0;
            z_p[0]    <= {4'b0000, acc[29:16], 2'b00};
            quad_p[0] <= acc[31:30];
            byp_p[0]  <= (acc[29:16] == 14'd0);
            for (int i = 0; i < ITER; i++) begin
                if (!z_p[i][19]) begin
                    x_p[i+1] <= x_p[i] - (y_p[i] >>> i);
                    y_p[i+1] <= y_p[i] + (x_p[i] >>> i);
                end else begin
                    x_p[i+1] <= x_p[i] + (y_p[i] >>> i);
                    y_p[i+1] <= y_p[i] - (x_p[i] >>> i);
                end
                quad_p[i+1] <= quad_p[i];
                byp_p[i+1]  <= byp_p[i];
            end
            for (int i = 0; i < ITER - 1; i++)
                z_p[i+1] <= z_p[i][19] ? z_p[i] + atan_lut(i) : z_p[i] - atan_lut(i);
        end
    end

    // Stage p15: round, exact-axis bypass, quadrant unfold
    always_comb begin
        sin_f = rnd_sat(y_p[ITER]);
        cos_f = rnd_sat(x_p[ITER]);
        if (byp_p[ITER]) begin
            sin_f = 10'sd0;
            cos_f = 10'sd511;
        end
        case (quad_p[ITER])
            2'd0: begin sin_u = sin_f;  cos_u = cos_f;  end
            2'd1: begin sin_u = cos_f;  cos_u = -sin_f; end
            2'd2: begin sin_u = -sin_f; cos_u = -cos_f; end
            default: begin sin_u = -cos_f; cos_u = sin_f; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsin_o    <= '0;
            fcos_o    <= '0;
            out_valid <= 1'b0;
        end else if (clken) begin
            fsin_o    <= vld_p[14] ? sin_u : 10'sd0;
            fcos_o    <= vld_p[14] ? cos_u : 10'sd0;
            out_valid <= vld_p[14];
        end
    end

endmodule

// File: tb/tb_mnco_sdr.sv
// Directed testbench for mnco_sdr: reset, quarter-rate, DC/Nyquist, fine tone,
// clock enable and mid-stream reset / increment change.
module tb_mnco_sdr;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               clken = 1'b0;
    logic        [31:0] phi_inc_i = '0;
    logic signed [9:0]  fsin_o;
    logic signed [9:0]  fcos_o;
    logic               out_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mnco_sdr dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .phi_inc_i (phi_inc_i),
        .fsin_o    (fsin_o),
        .fcos_o    (fcos_o),
        .out_valid (out_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int q_sin(input int j);
        case (j % 4)
            0: return 0;
            1: return 511;
            2: return 0;
            default: return -511;
        endcase
    endfunction

    function automatic int q_cos(input int j);
        case (j % 4)
            0: return 511;
            1: return 0;
            2: return -511;
            default: return 0;
        endcase
    endfunction

    // One reset edge with clken high, then release
    task automatic start(input logic [31:0] inc);
        reset_n   = 1'b0;
        clken     = 1'b1;
        phi_inc_i = inc;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clken     = 1'b1;
        phi_inc_i = 32'h4000_0000;
        reset_n   = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || fsin_o !== 10'sd0 || fcos_o !== 10'sd0) begin
                n_err++;
                $display("FAIL reset_hold cyc %0d: valid=%b sin=%0d cos=%0d, want 0/0/0",
                         c, out_valid, fsin_o, fcos_o);
            end
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            n_cmp++;
            if (n < 16) begin
                if (out_valid !== 1'b0 || fsin_o !== 10'sd0 || fcos_o !== 10'sd0) begin
                    n_err++;
                    $display("FAIL reset_release edge %0d: valid=%b sin=%0d cos=%0d, want 0/0/0",
                             n, out_valid, fsin_o, fcos_o);
                end
            end else if (out_valid !== 1'b1 || fsin_o !== 10'sd0 || fcos_o !== 10'sd511) begin
                n_err++;
                $display("FAIL first_valid: valid=%b sin=%0d cos=%0d, want 1/0/511",
                         out_valid, fsin_o, fcos_o);
            end
        end
    endtask

    task automatic test_quarter_rate();
        start(32'h4000_0000);
        for (int n = 1; n < 16; n++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL quarter_latency edge %0d: valid=%b, want 0", n, out_valid);
            end
        end
        for (int n = 16; n < 32; n++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || int'(fsin_o) != q_sin(n - 16) || int'(fcos_o) != q_cos(n - 16)) begin
                n_err++;
                $display("FAIL quarter k=%0d: valid=%b sin=%0d cos=%0d, want 1/%0d/%0d",
                         n - 16, out_valid, fsin_o, fcos_o, q_sin(n - 16), q_cos(n - 16));
            end
        end
    endtask

    task automatic test_dc_nyquist();
        start(32'h0000_0000);
        repeat (15) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || fsin_o !== 10'sd0 || fcos_o !== 10'sd511) begin
                n_err++;
                $display("FAIL dc k=%0d: valid=%b sin=%0d cos=%0d, want 1/0/511",
                         k, out_valid, fsin_o, fcos_o);
            end
        end
        start(32'h8000_0000);
        repeat (15) tick();
        for (int k = 0; k < 8; k++) begin
            int ec;
            ec = (k % 2 == 0) ? 511 : -511;
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || fsin_o !== 10'sd0 || int'(fcos_o) != ec) begin
                n_err++;
                $display("FAIL nyquist k=%0d: valid=%b sin=%0d cos=%0d, want 1/0/%0d",
                         k, out_valid, fsin_o, fcos_o, ec);
            end
        end
    endtask

    task automatic test_fine_tone();
        int hs [256];
        int hc [256];
        start(32'h0100_0000);
        repeat (15) tick();
        for (int k = 0; k < 1024; k++) begin
            real rs, rc, ang;
            int  es, ec, ds, dc;
            ang = 2.0 * 3.14159265358979 * real'(k % 256) / 256.0;
            rs  = 511.0 * $sin(ang);
            rc  = 511.0 * $cos(ang);
            es  = (rs >= 0.0) ? $rtoi(rs + 0.5) : -$rtoi(-rs + 0.5);
            ec  = (rc >= 0.0) ? $rtoi(rc + 0.5) : -$rtoi(-rc + 0.5);
            tick();
            ds = int'(fsin_o) - es;
            dc = int'(fcos_o) - ec;
            n_cmp++;
            if (out_valid !== 1'b1 || ds > 1 || ds < -1 || dc > 1 || dc < -1 ||
                fsin_o == -10'sd512 || fcos_o == -10'sd512) begin
                n_err++;
                $display("FAIL fine k=%0d: valid=%b sin=%0d cos=%0d, want 1/%0d/%0d +-1",
                         k, out_valid, fsin_o, fcos_o, es, ec);
            end
            if (k < 256) begin
                hs[k] = int'(fsin_o);
                hc[k] = int'(fcos_o);
            end else begin
                n_cmp++;
                if (int'(fsin_o) != hs[k % 256] || int'(fcos_o) != hc[k % 256]) begin
                    n_err++;
                    $display("FAIL fine_period k=%0d: sin=%0d cos=%0d, want %0d/%0d",
                             k, fsin_o, fcos_o, hs[k % 256], hc[k % 256]);
                end
            end
        end
    endtask

    task automatic test_clken();
        int ne;
        int es, ec;
        logic ev;
        start(32'h4000_0000);
        ne = 0;
        for (int c = 0; c < 100; c++) begin
            clken = ($urandom_range(0, 2) != 0);
            tick();
            if (clken) ne++;
            ev = (ne >= 16);
            es = ev ? q_sin(ne - 16) : 0;
            ec = ev ? q_cos(ne - 16) : 0;
            n_cmp++;
            if (out_valid !== ev || int'(fsin_o) != es || int'(fcos_o) != ec) begin
                n_err++;
                $display("FAIL clken cyc %0d en=%b ne=%0d: valid=%b sin=%0d cos=%0d, want %b/%0d/%0d",
                         c, clken, ne, out_valid, fsin_o, fcos_o, ev, es, ec);
            end
        end
        clken = 1'b1;
    endtask

    task automatic test_back_to_back();
        int es, ec, j;
        logic ev;
        start(32'h4000_0000);
        repeat (20) tick();
        reset_n = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || fsin_o !== 10'sd0 || fcos_o !== 10'sd0) begin
            n_err++;
            $display("FAIL mid_reset: valid=%b sin=%0d cos=%0d, want 0/0/0", out_valid, fsin_o, fcos_o);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 21) phi_inc_i = 32'h8000_0000;
            tick();
            j  = n - 16;
            ev = (n >= 16);
            if (!ev) begin
                es = 0; ec = 0;
            end else if (j <= 20) begin
                es = q_sin(j); ec = q_cos(j);
            end else begin
                es = 0; ec = ((j - 20) % 2 == 1) ? -511 : 511;
            end
            n_cmp++;
            if (out_valid !== ev || int'(fsin_o) != es || int'(fcos_o) != ec) begin
                n_err++;
                $display("FAIL restart_inc edge %0d: valid=%b sin=%0d cos=%0d, want %b/%0d/%0d",
                         n, out_valid, fsin_o, fcos_o, ev, es, ec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_quarter_rate();
        test_dc_nyquist();
        test_fine_tone();
        test_clken();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mnco_sdr.md
Name: mnco_sdr

Overview:
- Numerically controlled oscillator for the SDR receiver's digital down-converter.
- A 32-bit phase accumulator advances by a programmable phase increment each enabled clock.
- The phase drives a pipelined sine/cosine generator that produces 10-bit two's-complement quadrature outputs for the I/Q mixers.

Parameters:
- None. All widths and the latency are fixed: accumulator 32 bits, outputs 10 bits, latency 16 enabled cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, synchronous, active-low; sampled on the clk rising edge.
- clken  input  1  clock enable. When low, all state (accumulator, pipeline, valid) holds.
- phi_inc_i  input  32  unsigned phase increment; output frequency = phi_inc_i * f_clk / 2^32.
- fsin_o  output  10  signed sine sample, amplitude 511.
- fcos_o  output  10  signed cosine sample, amplitude 511.
- out_valid  output  1  high when fsin_o/fcos_o carry a valid sample.

Behaviour:
- Reset:
  - reset_n low at a rising edge clears the accumulator, every pipeline register, fsin_o=0, fcos_o=0 and out_valid=0.
  - Reset takes priority over clken and also applies when clken=0.
- Phase accumulator:
  - On each edge with reset_n=1 and clken=1: acc <= acc + phi_inc_i, modulo 2^32 with natural wrap and no saturation.
  - Sample k (k=0,1,2,… counted in enabled cycles after reset release) uses phase acc_k = k*phi_inc_i mod 2^32. Sample 0 is phase 0.
  - phi_inc_i is sampled every enabled cycle. A change affects the next accumulated phase; the outputs reflect it 16 enabled cycles later.
- Phase-to-amplitude:
  - Use the top 16 bits of the phase.
  - Top 2 bits select the quadrant; fold to the first quadrant and compute with a pipelined CORDIC of at least 14 iterations, or an equivalent method.
  - Unfold the signs by quadrant.
  - Round and saturate to [-511, +511]; -512 is never produced.
- Accuracy:
  - fsin_o = round(511*sin(2π·acc/2^32)) and fcos_o = round(511*cos(2π·acc/2^32)), within ±1 LSB.
  - At phases that are exact multiples of 2^30 (0°, 90°, 180°, 270°), the outputs are exact: (sin,cos) = (0,511), (511,0), (0,-511), (-511,0). These are produced by a bypass on the folded-residual-zero case.
- Latency and valid:
  - A 16-deep valid shift register is fed with 1 after reset and advances only on enabled cycles.
  - out_valid rises at the 16th enabled rising edge after the first edge with reset_n=1. At that edge the outputs present sample 0.
  - Thereafter out_valid stays high, with one new sample per enabled cycle.
  - Before out_valid rises, the outputs are 0.
- clken low:
  - Outputs and out_valid hold their last values.
  - No samples are lost or duplicated: the enabled-cycle sample sequence is identical to the sequence with clken held high.
- Reset mid-operation:
  - At the reset edge, out_valid falls and the outputs go to 0.
  - After release, the sequence restarts from phase 0 with the same 16-cycle latency.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset hold: reset_n=0 for 7 cycles with clken=1 and phi_inc_i=0x40000000 -> out_valid=0 and fsin_o=fcos_o=0 on every cycle; the values stay 0 until the 16th edge after release.
- Quarter-rate tone: phi_inc_i=0x40000000 with clken=1 after reset -> out_valid rises at the 16th edge after release; the sin sequence is 0,511,0,-511 repeating and the cos sequence is 511,0,-511,0, exact.
- DC and Nyquist:
  - phi_inc_i=0 -> constant sin=0, cos=511.
  - phi_inc_i=0x80000000 -> sin=0 always; cos alternates 511,-511.
- Fine tone and wrap: phi_inc_i=0x01000000 for 1024 samples -> every sample within ±1 LSB of round(511·sin/cos(2πk/256)); no output equals -512; the pattern is periodic over 256 samples across accumulator wrap.
- Clock enable: phi_inc_i=0x40000000 with clken toggled pseudo-randomly -> outputs and out_valid frozen while clken=0; the enabled-cycle sample sequence matches the quarter-rate tone case exactly.
- Mid-stream reset and increment change:
  - Pulse reset_n low for 1 cycle mid-stream -> out_valid=0 and outputs=0 on the next edge; valid returns 16 enabled edges later, starting at sin=0, cos=511.
  - Switch phi_inc_i from 0x40000000 to 0x80000000 -> the new pattern appears exactly 16 enabled cycles after the change.
